// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared state encoding and segment patterns for the
//               two-digit multiplexed 7-segment driver.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    typedef enum logic [1:0] {
        S_UNI  = 2'd0,
        S_GAP1 = 2'd1,
        S_DEC  = 2'd2,
        S_GAP2 = 2'd3
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Anodes {decenas,unidades}, active-low
    localparam logic [1:0] AN_OFF = 2'b11;
    localparam logic [1:0] AN_UNI = 2'b10;
    localparam logic [1:0] AN_DEC = 2'b01;

endpackage
`default_nettype wire

// File: rtl/decod_bcd_7seg.sv
`default_nettype none
// ============================================================================
// Module      : decod_bcd_7seg
// Description : Combinational BCD to active-low 7-segment decoder; non-BCD
//               codes show a dash.
// Revision    : 1.0 - initial release
// ============================================================================
module decod_bcd_7seg
    import display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_bcd <= 4'd9) begin
            o_seg = SEG_DIGITS[i_bcd];
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_7seg_mux.sv
`default_nettype none
// ============================================================================
// Module      : display_7seg_mux
// Description : Two-digit common-anode display multiplexer with per-frame
//               digit snapshot, dead-time gaps and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module display_7seg_mux
    import display_pkg::*;
#(
    parameter int DIV_REFRESH = 50000,
    parameter int DEAD_CYCLES = 500,
    parameter int BLANK_CERO  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] unidades,
    input  logic [3:0] decenas,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame
);

    localparam int c_cnt_max = (DIV_REFRESH > DEAD_CYCLES) ? DIV_REFRESH : DEAD_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam logic [c_cnt_w-1:0] c_last_lit = c_cnt_w'(DIV_REFRESH - 1);
    localparam logic [c_cnt_w-1:0] c_last_gap = c_cnt_w'(DEAD_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic [3:0]           r_snap_uni;
    logic [3:0]           r_snap_dec;
    logic [3:0]           w_snap_uni_next;
    logic [3:0]           w_snap_dec_next;
    logic                 w_last;
    logic                 w_enter_uni;
    logic [3:0]           w_sel_bcd;
    logic [6:0]           w_sel_seg;
    logic [6:0]           w_seg_next;
    logic [1:0]           w_an_next;
    logic                 w_frame_next;
    logic [6:0]           r_seg;
    logic [1:0]           r_an;
    logic                 r_frame;

    // Dwell counter counts up from 0 on each state entry
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_last       = 1'b0;

        case (r_state)
            S_UNI, S_DEC: w_last = (r_cnt == c_last_lit);
            default:      w_last = (r_cnt == c_last_gap);
        endcase

        if (w_last) begin
            w_cnt_next = '0;
            case (r_state)
                S_UNI:   w_state_next = S_GAP1;
                S_GAP1:  w_state_next = S_DEC;
                S_DEC:   w_state_next = S_GAP2;
                default: w_state_next = S_UNI;
            endcase
        end

        w_enter_uni     = w_last && (r_state == S_GAP2);
        w_snap_uni_next = w_enter_uni ? unidades : r_snap_uni;
        w_snap_dec_next = w_enter_uni ? decenas  : r_snap_dec;
        w_sel_bcd       = (w_state_next == S_DEC) ? w_snap_dec_next : w_snap_uni_next;
    end

    decod_bcd_7seg u_decod (
        .i_bcd (w_sel_bcd),
        .o_seg (w_sel_seg)
    );

    // Outputs are computed for the state being entered so they register together
    always_comb begin
        w_an_next    = AN_OFF;
        w_seg_next   = SEG_BLANK;
        w_frame_next = w_enter_uni;

        case (w_state_next)
            S_UNI: begin
                w_an_next  = AN_UNI;
                w_seg_next = w_sel_seg;
            end
            S_DEC: begin
                if (!((BLANK_CERO != 0) && (w_snap_dec_next == 4'd0))) begin
                    w_an_next  = AN_DEC;
                    w_seg_next = w_sel_seg;
                end
            end
            default: begin
                w_an_next  = AN_OFF;
                w_seg_next = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_GAP2;
            r_cnt      <= '0;
            r_snap_uni <= 4'd0;
            r_snap_dec <= 4'd0;
            r_an       <= AN_OFF;
            r_seg      <= SEG_BLANK;
            r_frame    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_snap_uni <= w_snap_uni_next;
            r_snap_dec <= w_snap_dec_next;
            r_an       <= w_an_next;
            r_seg      <= w_seg_next;
            r_frame    <= w_frame_next;
        end
    end

    assign seg   = r_seg;
    assign an    = r_an;
    assign frame = r_frame;

endmodule
`default_nettype wire
